instr_prefetch: RTL and testbench

Instruction prefetch stage sitting directly upstream of the dual-port word ROM's instruction port. Drives a word-aligned fetch address into the ROM every cycle and captures the combinational read data into a small FIFO of {pc, instr} entries. Presents instructions to decode through a valid/ready handshake. Supports a single-cycle redirect (branch/jump/trap) that flushes all buffered entries.

---
 rtl/instr_prefetch.sv | 132 +++++++++++++
 tb/tb_instr_prefetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch: drives a word-aligned fetch address into the ROM every cycle and
// buffers {pc, instr, misaligned} in a FIFO for decode. FETCH_PERF_CNT_EN adds stall/redirect counters.
module instr_prefetch #(
    parameter int                    ADDR_WIDTH = 15,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_redirects,
`endif
    output logic                  out_misaligned
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           instr;
        logic                  misaligned;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop;
    logic                  push;
    entry_t                head;

    assign head           = mem_q[rd_ptr_q];
    assign rom_addr       = pc_q;
    assign out_valid      = (count_q != '0);
    assign out_instr      = head.instr;
    assign out_pc         = head.pc;
    assign out_misaligned = head.misaligned;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        pc_d     = pc_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;
        push     = 1'b0;

        if (redirect_valid) begin
            // Redirect discards everything, including a handshake decode thought it completed.
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            pop  = out_valid & out_ready;
            push = (count_q != FULL_COUNT) | pop;
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: rom_rdata, misaligned: (pc_q[1:0] != 2'b00)};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                pc_d            = {pc_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset so the head outputs read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_redir_d = perf_redir_q;
        if (out_valid && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_valid && (perf_redir_q != '1)) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed per-cycle vector table, a mid-stream reset
// sequence, and randomized traffic checked against a queue-based reference model.
module tb_instr_prefetch;

    localparam int AW    = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          out_misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_redirects;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instr_prefetch #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects),
`endif
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    // ROM contents: word n holds (n+1)*0x11111111; misaligned reads get their low address bits mixed in.
    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return (((32'(a) >> 2) + 32'd1) * 32'h11111111) ^ {30'd0, a[1:0]};
    endfunction

    always_comb rom_rdata = rom_word(rom_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic          rst;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          rdy;
        logic          ev;
        logic [AW-1:0] epc;
        logic          emis;
        logic [AW-1:0] era;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic rv, input int rpc, input logic rdy,
                                input logic ev, input int epc, input logic emis, input int era);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = AW'(rpc); v.rdy = rdy;
        v.ev = ev; v.epc = AW'(epc); v.emis = emis; v.era = AW'(era);
        vecs.push_back(v);
    endfunction

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        logic          mis;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] mpc;
    int            m_stall;
    int            m_redir;

    initial begin
        // Streaming from reset with decode always ready.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 'h0, 0, 'h4);
        add(0, 0, 0, 1, 1, 'h4, 0, 'h8);
        add(0, 0, 0, 1, 1, 'h8, 0, 'hC);
        // Back-pressure fills the FIFO, fetch holds at 0x10, then drains with no gap.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 0, 0, k >= 1, 'h0, 0, 4 * ((k < 4) ? k : 4));
        for (int j = 0; j < 8; j++) add(0, 0, 0, 1, 1, 4 * j, 0, 'h10 + 4 * j);
        // Redirect while full with out_ready high.
        add(0, 1, 'h200, 1, 1, 'h20, 0, 'h30);
        add(0, 0, 0, 1, 0, 0, 0, 'h200);
        add(0, 0, 0, 1, 1, 'h200, 0, 'h204);
        // Misaligned redirect target, alignment restored on the next entry.
        add(0, 1, 'h102, 0, 1, 'h204, 0, 'h208);
        add(0, 0, 0, 0, 0, 0, 0, 'h102);
        add(0, 0, 0, 1, 1, 'h102, 1, 'h104);
        add(0, 0, 0, 1, 1, 'h104, 0, 'h108);
        // PC wrap at the top of the address space.
        add(0, 1, 'h7FFC, 1, 1, 'h108, 0, 'h10C);
        add(0, 0, 0, 1, 0, 0, 0, 'h7FFC);
        add(0, 0, 0, 1, 1, 'h7FFC, 0, 'h0);
        add(0, 0, 0, 1, 1, 'h0, 0, 'h4);
        // Back-to-back redirects: the last one wins.
        add(0, 1, 'h300, 1, 1, 'h4, 0, 'h8);
        add(0, 1, 'h400, 1, 0, 0, 0, 'h300);
        add(0, 0, 0, 1, 0, 0, 0, 'h400);
        add(0, 0, 0, 1, 1, 'h400, 0, 'h404);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n          = !vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d.rom_addr", i), 64'(rom_addr), 64'(vecs[i].era));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d.pc", i), 64'(out_pc), 64'(vecs[i].epc));
                check($sformatf("vec%0d.instr", i), 64'(out_instr), 64'(rom_word(vecs[i].epc)));
                check($sformatf("vec%0d.mis", i), 64'(out_misaligned), 64'(vecs[i].emis));
            end
            if (vecs[i].rst) begin
                check($sformatf("vec%0d.rst_pc", i), 64'(out_pc), 64'h0);
                check($sformatf("vec%0d.rst_instr", i), 64'(out_instr), 64'h0);
                check($sformatf("vec%0d.rst_mis", i), 64'(out_misaligned), 64'h0);
            end
            @(negedge clk);
        end

        // Stall a few cycles, redirect twice, then reset asynchronously mid-stream.
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            redirect_valid = (c == 6) || (c == 7);
            redirect_pc    = AW'('h40);
            out_ready      = (c >= 6);
            @(negedge clk);
        end
        #1;
        check("stream.valid_before_reset", 64'(out_valid), 64'h1);
`ifdef FETCH_PERF_CNT_EN
        check("perf.stall", 64'(perf_stall_cycles), 64'd5);
        check("perf.redirects", 64'(perf_redirects), 64'd2);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.valid", 64'(out_valid), 64'h0);
        check("async_reset.rom_addr", 64'(rom_addr), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        check("async_reset.perf_stall", 64'(perf_stall_cycles), 64'd0);
        check("async_reset.perf_redir", 64'(perf_redirects), 64'd0);
`endif

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mpc     = '0;
        m_stall = 0;
        m_redir = 0;
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias           = ((i / 250) % 2 == 1) ? 30 : 85;
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? AW'(32'h7FF0 | $urandom_range(0, 15))
                                                        : AW'($urandom_range(0, 32767));
            out_ready      = ($urandom_range(0, 99) < bias);
            #1;
            check("rnd.valid", 64'(out_valid), 64'(mq.size() != 0));
            check("rnd.rom_addr", 64'(rom_addr), 64'(mpc));
            if (mq.size() != 0) begin
                check("rnd.pc", 64'(out_pc), 64'(mq[0].pc));
                check("rnd.instr", 64'(out_instr), 64'(mq[0].instr));
                check("rnd.mis", 64'(out_misaligned), 64'(mq[0].mis));
            end
`ifdef FETCH_PERF_CNT_EN
            check("rnd.perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
            check("rnd.perf_redir", 64'(perf_redirects), 64'(m_redir));
`endif
            if (mq.size() != 0 && !out_ready) m_stall++;
            if (redirect_valid) begin
                m_redir++;
                mq.delete();
                mpc = redirect_pc;
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (mq.size() != 0) && out_ready;
                do_push = (mq.size() < DEPTH) || do_pop;
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    ent_t e;
                    e.pc    = mpc;
                    e.instr = rom_word(mpc);
                    e.mis   = (int'(mpc) % 4) != 0;
                    mq.push_back(e);
                    mpc = AW'(((int'(mpc) / 4) * 4 + 4) % (1 << AW));
                end
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
